// File: rtl/ct_pmp_chk_pipe_if.sv
// Request/response, PMP-port and fault-capture bundle for ct_pmp_chk_pipe.
// flt_cnt exists only when PMP_CHK_FAULT_CNT_EN is defined.
interface ct_pmp_chk_pipe_if #(
   parameter int TAG_W = 4
`ifdef PMP_CHK_FAULT_CNT_EN
  ,parameter int CNT_W = 16
`endif
);
   logic             req_vld;
   logic             req_rdy;
   logic [27:0]      req_pa;
   logic [1:0]       req_type;
   logic [TAG_W-1:0] req_tag;
   logic [27:0]      chk_pmp_pa;
   logic [3:0]       pmp_chk_flg;
   logic             cp0_pmp_wreg;
   logic             rsp_vld;
   logic             rsp_rdy;
   logic             rsp_fault;
   logic [TAG_W-1:0] rsp_tag;
   logic [27:0]      rsp_pa;
   logic             flt_vld;
   logic [27:0]      flt_pa;
   logic [1:0]       flt_type;
   logic             flt_clr;
`ifdef PMP_CHK_FAULT_CNT_EN
   logic [CNT_W-1:0] flt_cnt;
`endif

   // Master is the MMU/LSU + PMP + CP0 environment; slave is the check pipe.
   modport master (
      output req_vld, req_pa, req_type, req_tag, pmp_chk_flg, cp0_pmp_wreg, rsp_rdy, flt_clr,
      input  req_rdy, chk_pmp_pa, rsp_vld, rsp_fault, rsp_tag, rsp_pa, flt_vld, flt_pa, flt_type
`ifdef PMP_CHK_FAULT_CNT_EN
     ,input  flt_cnt
`endif
   );

   modport slave (
      input  req_vld, req_pa, req_type, req_tag, pmp_chk_flg, cp0_pmp_wreg, rsp_rdy, flt_clr,
      output req_rdy, chk_pmp_pa, rsp_vld, rsp_fault, rsp_tag, rsp_pa, flt_vld, flt_pa, flt_type
`ifdef PMP_CHK_FAULT_CNT_EN
     ,output flt_cnt
`endif
   );
endinterface

// File: rtl/ct_pmp_chk_pipe.sv
// Two-stage registered wrapper in front of one PMP check port with sticky first-fault capture.
// Optional saturating fault counter (flt_cnt) enabled by defining PMP_CHK_FAULT_CNT_EN.
module ct_pmp_chk_pipe #(
   parameter int TAG_W = 4
`ifdef PMP_CHK_FAULT_CNT_EN
  ,parameter int CNT_W = 16
`endif
) (
   input logic              forever_cpuclk,
   input logic              cpurst,
   ct_pmp_chk_pipe_if.slave bus
);
   typedef enum logic [1:0] {
      TYPE_LOAD  = 2'd0,
      TYPE_STORE = 2'd1,
      TYPE_FETCH = 2'd2,
      TYPE_RSVD  = 2'd3
   } acc_type_e;

   logic             r_s1_vld;
   logic [27:0]      r_s1_pa;
   acc_type_e        r_s1_type;
   logic [TAG_W-1:0] r_s1_tag;
   logic             r_s2_vld;
   logic             r_s2_fault;
   logic [TAG_W-1:0] r_s2_tag;
   logic [27:0]      r_s2_pa;
   logic             r_flt_vld;
   logic [27:0]      r_flt_pa;
   logic [1:0]       r_flt_type;

   logic w_s1_adv;
   logic w_req_rdy;
   logic w_req_acc;
   logic w_fault;
   logic w_flt_evt;
   logic w_flt_set;
   logic w_unused_nomatch;

   // S1 never advances during a CSR write, so a flag from that cycle is never consumed.
   assign w_s1_adv  = r_s1_vld & ~bus.cp0_pmp_wreg & (~r_s2_vld | bus.rsp_rdy);
   assign w_req_rdy = ~r_s1_vld | w_s1_adv;
   assign w_req_acc = bus.req_vld & w_req_rdy;

   // The PMP already folds default-deny into R/W/X, so no-match is informational only.
   assign w_unused_nomatch = bus.pmp_chk_flg[3];

   // NOTE: assign the default before the case so every path drives w_fault and no latch is inferred.
   always_comb begin
      w_fault = 1'b1;
      case (r_s1_type)
         TYPE_LOAD:  w_fault = ~bus.pmp_chk_flg[0];
         TYPE_STORE: w_fault = ~bus.pmp_chk_flg[1];
         TYPE_FETCH: w_fault = ~bus.pmp_chk_flg[2];
         default:    w_fault = 1'b1;
      endcase
   end

   assign w_flt_evt = w_s1_adv & w_fault;
   assign w_flt_set = w_flt_evt & (~r_flt_vld | bus.flt_clr);

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         r_s1_vld  <= 1'b0;
         r_s1_pa   <= '0;
         r_s1_type <= TYPE_LOAD;
         r_s1_tag  <= '0;
      end else if (w_req_acc) begin
         r_s1_vld  <= 1'b1;
         r_s1_pa   <= bus.req_pa;
         r_s1_type <= acc_type_e'(bus.req_type);
         r_s1_tag  <= bus.req_tag;
      end else if (w_s1_adv) begin
         r_s1_vld  <= 1'b0;
      end
   end

   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         r_s2_vld   <= 1'b0;
         r_s2_fault <= 1'b0;
         r_s2_tag   <= '0;
         r_s2_pa    <= '0;
      end else if (w_s1_adv) begin
         r_s2_vld   <= 1'b1;
         r_s2_fault <= w_fault;
         r_s2_tag   <= r_s1_tag;
         r_s2_pa    <= r_s1_pa;
      end else if (bus.rsp_rdy) begin
         r_s2_vld   <= 1'b0;
      end
   end

   // A fault coinciding with flt_clr is captured: set wins over clear.
   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         r_flt_vld  <= 1'b0;
         r_flt_pa   <= '0;
         r_flt_type <= '0;
      end else if (w_flt_set) begin
         r_flt_vld  <= 1'b1;
         r_flt_pa   <= r_s1_pa;
         r_flt_type <= r_s1_type;
      end else if (bus.flt_clr) begin
         r_flt_vld  <= 1'b0;
      end
   end

`ifdef PMP_CHK_FAULT_CNT_EN
   logic [CNT_W-1:0] r_flt_cnt;

   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         r_flt_cnt <= '0;
      end else if (bus.flt_clr) begin
         r_flt_cnt <= CNT_W'(w_flt_evt);
      end else if (w_flt_evt && (r_flt_cnt != '1)) begin
         r_flt_cnt <= r_flt_cnt + CNT_W'(1);
      end
   end

   assign bus.flt_cnt = r_flt_cnt;
`endif

   assign bus.req_rdy    = w_req_rdy;
   assign bus.chk_pmp_pa = r_s1_pa;
   assign bus.rsp_vld    = r_s2_vld;
   assign bus.rsp_fault  = r_s2_fault;
   assign bus.rsp_tag    = r_s2_tag;
   assign bus.rsp_pa     = r_s2_pa;
   assign bus.flt_vld    = r_flt_vld;
   assign bus.flt_pa     = r_flt_pa;
   assign bus.flt_type   = r_flt_type;
endmodule
